// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 streaming pooler.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2
    } state_e;

    localparam int DATA_W_DEF   = 8;
    localparam int CHANNELS_DEF = 1;

    // Helpers work on a wide carrier; callers zero-extend in and truncate out.
    localparam int FN_W = 32;

    function automatic logic [FN_W-1:0] max2(input logic [FN_W-1:0] a, input logic [FN_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [FN_W-1:0] max3(input logic [FN_W-1:0] a, input logic [FN_W-1:0] b,
                                             input logic [FN_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer holding one pooled-pair value per output column.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = 320,
    parameter int W     = 8,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Combinational read: the top row's pair is available on the odd column itself.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/max_pool_stream_2x2.sv
// Streaming 2x2/stride-2 pooler with valid/ready, frame/line markers and error recovery.
// Optional average pooling is enabled by defining AVG_POOL_EN.
module max_pool_stream_2x2
    import pool_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CHANNELS  = CHANNELS_DEF,
    parameter int MAX_WIDTH = 640,
    parameter int WCNT_W    = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WCNT_W-1:0]          cfg_width,
`ifdef AVG_POOL_EN
    input  logic                       pool_avg,
`endif
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [CHANNELS*DATA_W-1:0] s_data,
    input  logic                       s_sof,
    input  logic                       s_eol,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CHANNELS*DATA_W-1:0] m_data,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       err_frame
);

    localparam int PW    = CHANNELS * DATA_W;
`ifdef AVG_POOL_EN
    localparam int BUF_W = DATA_W + 1;
`else
    localparam int BUF_W = DATA_W;
`endif
    localparam int DEPTH = MAX_WIDTH / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   col_q, width_q;
    logic [PW-1:0]       hold_q;
    logic                sof_pend_q, err_q;
    logic                m_valid_q, m_sof_q, m_eol_q;
    logic [PW-1:0]       m_data_q;

    logic                acc, pair_ok, wr_en, emit, err_set;
    state_e              eff_st;
    logic [WCNT_W-1:0]   ecol, ewidth, pair_idx;
    logic [CHANNELS*BUF_W-1:0] wr_data, rd_data;
    logic [PW-1:0]       out_data;

    assign s_ready = !m_valid_q | m_ready;
    assign acc     = s_valid & s_ready;

    // An s_sof beat is always column 0 of a fresh EVEN_ROW, whatever came before.
    assign eff_st   = s_sof ? EVEN_ROW : state_q;
    assign ecol     = s_sof ? '0 : col_q;
    assign ewidth   = s_sof ? cfg_width : width_q;
    assign pair_idx = ecol >> 1;
    assign pair_ok  = ecol[0] && (pair_idx < (ewidth >> 1)) && (int'(pair_idx) < DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (acc && eff_st != IDLE) begin
            if (s_eol)      state_d = (eff_st == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            else if (s_sof) state_d = EVEN_ROW;
        end
    end

    always_comb begin
        wr_en   = acc && (eff_st == EVEN_ROW) && pair_ok;
        emit    = acc && (eff_st == ODD_ROW) && pair_ok;
        err_set = acc && (((eff_st != IDLE) && s_eol && (ecol != ewidth - 1'b1)) ||
                          (s_sof && (state_q != IDLE) && (col_q != '0)));
    end

`ifdef AVG_POOL_EN
    logic avg_q, eff_avg;
    assign eff_avg = s_sof ? pool_avg : avg_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              avg_q <= 1'b0;
        else if (acc && s_sof)  avg_q <= pool_avg;
    end
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0] px, hd;
        logic [BUF_W-1:0]  bf;
        assign px = s_data[c*DATA_W +: DATA_W];
        assign hd = hold_q[c*DATA_W +: DATA_W];
        assign bf = rd_data[c*BUF_W +: BUF_W];
`ifdef AVG_POOL_EN
        logic [DATA_W+1:0] sum4;
        assign sum4 = (DATA_W+2)'(bf) + (DATA_W+2)'(hd) + (DATA_W+2)'(px) + (DATA_W+2)'(2);
        assign wr_data[c*BUF_W +: BUF_W] = eff_avg ? (BUF_W'(hd) + BUF_W'(px))
                                                   : BUF_W'(max2(FN_W'(hd), FN_W'(px)));
        assign out_data[c*DATA_W +: DATA_W] = eff_avg ? DATA_W'(sum4 >> 2)
                                                      : DATA_W'(max3(FN_W'(hd), FN_W'(px), FN_W'(bf)));
`else
        assign wr_data[c*BUF_W +: BUF_W]    = BUF_W'(max2(FN_W'(hd), FN_W'(px)));
        assign out_data[c*DATA_W +: DATA_W] = DATA_W'(max3(FN_W'(hd), FN_W'(px), FN_W'(bf)));
`endif
    end

    pool_line_buf #(.DEPTH(DEPTH), .W(CHANNELS*BUF_W), .AW(AW)) u_line_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (AW'(pair_idx)),
        .wr_data_i (wr_data),
        .rd_addr_i (AW'(pair_idx)),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q      <= '0;
            width_q    <= '0;
            hold_q     <= '0;
            sof_pend_q <= 1'b0;
            err_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_sof_q    <= 1'b0;
            m_eol_q    <= 1'b0;
        end else begin
            if (acc) begin
                if (eff_st == IDLE || s_eol) col_q <= '0;
                else                         col_q <= ecol + 1'b1;
                if (!ecol[0]) hold_q <= s_data;
                if (s_sof) begin
                    width_q    <= cfg_width;
                    sof_pend_q <= 1'b1;
                end
            end
            if (err_set) err_q <= 1'b1;
            // Output register only loads when free or draining, so no beat is ever overwritten.
            if (emit) begin
                m_valid_q  <= 1'b1;
                m_data_q   <= out_data;
                m_sof_q    <= sof_pend_q;
                m_eol_q    <= (pair_idx == (ewidth >> 1) - 1'b1);
                sof_pend_q <= 1'b0;
            end else if (m_ready) begin
                m_valid_q  <= 1'b0;
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_sof     = m_sof_q;
    assign m_eol     = m_eol_q;
    assign err_frame = err_q;

endmodule

// File: tb/tb_max_pool_stream_2x2.sv
// Scoreboard bench for max_pool_stream_2x2: directed frames, expected beats queued, monitor compares.
module tb_max_pool_stream_2x2;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int MW = 640;
    localparam int WW = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic [WW-1:0]     cfg_width;
    logic              pool_avg;
    logic              s_valid, s_ready, s_sof, s_eol;
    logic [CH*DW-1:0]  s_data;
    logic              m_valid, m_ready, m_sof, m_eol, err_frame;
    logic [CH*DW-1:0]  m_data;

    typedef struct packed {
        logic [CH*DW-1:0] d;
        logic             sof;
        logic             eol;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    rmode = 0;
    int    qa[$];
    int    qb[$];

    always #5 clk = ~clk;

    max_pool_stream_2x2 #(.DATA_W(DW), .CHANNELS(CH), .MAX_WIDTH(MW), .WCNT_W(WW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_width (cfg_width),
`ifdef AVG_POOL_EN
        .pool_avg  (pool_avg),
`endif
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .err_frame (err_frame)
    );

    // Downstream ready: 0 = always ready, 1 = toggling, 2 = held off.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on every handshake, and checks stability during stalls.
    initial begin
        beat_t got, prev, e;
        bit    stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                got = {m_data, m_sof, m_eol};
                if (stall) begin
                    n_cmp++;
                    if (!m_valid || got !== prev) begin
                        n_err++;
                        $display("FAIL stall_hold: got v=%0b %h required v=1 %h", m_valid, got, prev);
                    end
                end
                if (m_valid && m_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_beat: got %h required no beat", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_err++;
                            $display("FAIL beat: got data=%h sof=%0b eol=%0b required data=%h sof=%0b eol=%0b",
                                     got.d, got.sof, got.eol, e.d, e.sof, e.eol);
                        end
                    end
                end
                stall = m_valid && !m_ready;
                prev  = got;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic exp_beat(input int c0, input int c1, input logic sof, input logic eol);
        exp_q.push_back({DW'(c1), DW'(c0), sof, eol});
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic px(input int c0, input int c1, input logic sof, input logic eol);
        bit ok;
        s_valid = 1'b1; s_data = {DW'(c1), DW'(c0)}; s_sof = sof; s_eol = eol;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); ok = s_ready;
            @(posedge clk); #1;
            if (ok) begin
                s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
                return;
            end
        end
        n_cmp++; n_err++;
        $display("FAIL px_timeout: got s_ready=0 for 100 cycles required 1");
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h);
        for (int i = 0; i < w * h; i++)
            px(qa[i], (i < qb.size()) ? qb[i] : 0, i == 0, (i % w) == w - 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d beats outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cfg_width = 4; pool_avg = 1'b0;
        s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_sof_eol", {m_sof, m_eol}, 0);
        chk("rst_err", 32'(err_frame), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 4x4 raster 0..15, always ready
        qa = '{0,1,2,3, 4,5,6,7, 8,9,10,11, 12,13,14,15}; qb = {};
        exp_beat(5, 0, 1, 0); exp_beat(7, 0, 0, 1);
        exp_beat(13, 0, 0, 0); exp_beat(15, 0, 0, 1);
        send_frame(4, 4);
        drain();
        chk("t1_err", 32'(err_frame), 0);

        // Same frame under toggling backpressure
        rmode = 1;
        exp_beat(5, 0, 1, 0); exp_beat(7, 0, 0, 1);
        exp_beat(13, 0, 0, 0); exp_beat(15, 0, 0, 1);
        send_frame(4, 4);
        drain();
        rmode = 0;

        // Odd width 5, odd height 3: last column and last row dropped
        cfg_width = 5;
        qa = '{10,3,7,20,99, 1,2,30,4,200, 50,60,70,80,90};
        exp_beat(10, 0, 1, 0); exp_beat(30, 0, 0, 1);
        send_frame(5, 3);
        drain();
        chk("t3_err", 32'(err_frame), 0);

        // Two channels, ch1 = 255 - ch0
        cfg_width = 4;
        qa = '{3,9,200,100, 6,1,50,150};
        qb = '{252,246,55,155, 249,254,205,105};
        exp_beat(9, 254, 1, 0); exp_beat(200, 205, 0, 1);
        send_frame(4, 2);
        drain();
        qb = {};

        // Short line, then a mid-row s_sof, then a clean frame
        px(5, 0, 1, 0); px(6, 0, 0, 0); px(7, 0, 0, 1);
        repeat (2) @(posedge clk); #1;
        chk("t5_err_short_eol", 32'(err_frame), 1);
        px(11, 0, 1, 0);
        qa = '{1,2,3,4, 8,7,6,5};
        exp_beat(8, 0, 1, 0); exp_beat(6, 0, 0, 1);
        send_frame(4, 2);
        drain();
        chk("t5_err_sticky", 32'(err_frame), 1);

        // Reset while a beat is stalled at the output
        rmode = 2;
        repeat (2) @(posedge clk); #1;
        cfg_width = 2;
        qa = '{9,3, 2,1};
        exp_beat(9, 0, 1, 1);
        send_frame(2, 2);
        @(posedge clk); #1;
        chk("rst_pending_valid", 32'(m_valid), 1);
        chk("rst_pending_data", 32'(m_data), 9);
        reset = 1'b1;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_err", 32'(err_frame), 0);
        exp_q.delete();
        rmode = 0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        // Beats without s_sof are dropped in IDLE
        px(50, 0, 0, 0); px(60, 0, 0, 1);
        qa = '{4,3, 2,1};
        exp_beat(4, 0, 1, 1);
        send_frame(2, 2);
        drain();
        chk("post_rst_err", 32'(err_frame), 0);

`ifdef AVG_POOL_EN
        pool_avg = 1'b1;
        qa = '{1,2, 2,2};
        exp_beat(2, 0, 1, 1);
        send_frame(2, 2);
        qa = '{0,0, 1,1};
        exp_beat(1, 0, 1, 1);
        send_frame(2, 2);
        drain();
        pool_avg = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
